// File: rtl/id_pkg.sv
// Shared definitions for the instruction-decode stage: default field widths,
// opcode names and the decoded-instruction record carried towards execute.
// No logic; imported by the decode-stage files.
package id_pkg;

   // Default geometry of the instruction word: opcode in the MSBs, two parameters below
   localparam int OPC_W_DEF   = 4;
   localparam int PARAM_W_DEF = 6;
   localparam int IMM_W_DEF   = 16;
   localparam int INSTR_W_DEF = OPC_W_DEF + 2 * PARAM_W_DEF;

   // Opcode assignments of the default 4-bit encoding
   localparam logic [OPC_W_DEF-1:0] OP_NOP  = 4'h0;
   localparam logic [OPC_W_DEF-1:0] OP_ADD  = 4'h1;
   localparam logic [OPC_W_DEF-1:0] OP_ADDI = 4'h2;
   localparam logic [OPC_W_DEF-1:0] OP_SUBI = 4'h3;
   localparam logic [OPC_W_DEF-1:0] OP_SUB  = 4'h4;
   localparam logic [OPC_W_DEF-1:0] OP_AND  = 4'h5;
   localparam logic [OPC_W_DEF-1:0] OP_OR   = 4'h6;
   localparam logic [OPC_W_DEF-1:0] OP_XOR  = 4'h7;
   localparam logic [OPC_W_DEF-1:0] OP_LD   = 4'h8;
   localparam logic [OPC_W_DEF-1:0] OP_ST   = 4'h9;
   localparam logic [OPC_W_DEF-1:0] OP_BEQ  = 4'hA;
   localparam logic [OPC_W_DEF-1:0] OP_JMP  = 4'hB;

   // Decoded instruction at the default widths; the stage uses the same field order
   typedef struct packed {
      logic [OPC_W_DEF-1:0]   opcode;
      logic [PARAM_W_DEF-1:0] p1;
      logic [PARAM_W_DEF-1:0] p2;
      logic [IMM_W_DEF-1:0]   imm;
      logic                   is_imm;
      logic                   illegal;
   } id_decoded_t;

endpackage

// File: rtl/id_skid_buf.sv
// Generic 2-entry valid/ready skid buffer (MAIN drives outputs, SKID catches overflow).
// Latency: a beat accepted at edge N is on out_dat after edge N.
// Backpressure: in_rdy is registered and drops only while both entries are held.
module id_skid_buf
   import id_pkg::*;
#(
   parameter int W = 8
)(
   input  logic         core_clk,
   input  logic         arst_n,
   input  logic         flush,
   input  logic         in_vld,
   output logic         in_rdy,
   input  logic [W-1:0] in_dat,
   output logic         out_vld,
   input  logic         out_rdy,
   output logic [W-1:0] out_dat
);

   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

   state_t       state_q, state_d;
   logic         in_rdy_q;
   logic [W-1:0] main_q, skid_q;
   logic         load_main_in, load_main_skid, load_skid;
   logic         accept, drain;

   assign accept  = in_vld & in_rdy_q;
   assign drain   = (state_q != EMPTY) & out_rdy;
   assign in_rdy  = in_rdy_q;
   assign out_vld = (state_q != EMPTY);
   assign out_dat = main_q;

   // Next occupancy and which entry loads what; flush wins over everything
   always_comb begin
      state_d        = state_q;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (accept) begin
                  state_d      = ONE;
                  load_main_in = 1'b1;
               end
            end
            ONE: begin
               if (accept && drain) begin
                  load_main_in = 1'b1;
               end else if (accept) begin
                  state_d   = FULL;
                  load_skid = 1'b1;
               end else if (drain) begin
                  state_d = EMPTY;
               end
            end
            FULL: begin
               if (drain) begin
                  state_d        = ONE;
                  load_main_skid = 1'b1;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   // Occupancy register; ready is precomputed so it never depends on out_rdy combinationally
   always_ff @(posedge core_clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q  <= EMPTY;
         in_rdy_q <= 1'b1;
      end else begin
         state_q  <= state_d;
         in_rdy_q <= (state_d != FULL);
      end
   end

   // Payload entries; SKID promotes into MAIN on the draining edge so order is kept
   always_ff @(posedge core_clk or negedge arst_n) begin
      if (!arst_n) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         if (load_main_in)        main_q <= in_dat;
         else if (load_main_skid) main_q <= skid_q;
         if (load_skid)           skid_q <= in_dat;
      end
   end

endmodule

// File: rtl/id_decode_stage.sv
// Instruction decode between fetch and execute: field split, immediate sign-extension, illegal flag.
// Latency: one cycle (decode is registered in the skid buffer), throughput one beat per cycle.
// Backpressure: 2-entry skid buffer, ID_in_ready registered; optional stall counter under ID_PERF_EN.
module id_decode_stage
   import id_pkg::*;
#(
   parameter int                  INSTR_W    = INSTR_W_DEF,
   parameter int                  OPC_W      = OPC_W_DEF,
   parameter int                  PARAM_W    = PARAM_W_DEF,
   parameter int                  IMM_W      = IMM_W_DEF,
   parameter logic [2**OPC_W-1:0] LEGAL_MASK = '1,
   parameter logic [2**OPC_W-1:0] IMM_MASK   = '0
)(
   input  logic               ID_clock,
   input  logic               ID_reset,
   input  logic               ID_flush,
   input  logic               ID_in_valid,
   output logic               ID_in_ready,
   input  logic [INSTR_W-1:0] ID_instruction,
   output logic               ID_out_valid,
   input  logic               ID_out_ready,
   output logic [OPC_W-1:0]   opcode,
   output logic [PARAM_W-1:0] parameter1,
   output logic [PARAM_W-1:0] parameter2,
   output logic [IMM_W-1:0]   immediate,
   output logic               is_imm,
   output logic               illegal,
   output logic [15:0]        stall_cycles
);

   // Same layout as id_decoded_t, sized by this instance's parameters
   typedef struct packed {
      logic [OPC_W-1:0]   opcode;
      logic [PARAM_W-1:0] p1;
      logic [PARAM_W-1:0] p2;
      logic [IMM_W-1:0]   imm;
      logic               is_imm;
      logic               illegal;
   } dec_t;

   if (INSTR_W != OPC_W + 2 * PARAM_W) begin : g_bad_instr_w
      $error("id_decode_stage: INSTR_W must equal OPC_W + 2*PARAM_W");
   end
   if (IMM_W < PARAM_W) begin : g_bad_imm_w
      $error("id_decode_stage: IMM_W must be at least PARAM_W");
   end

   dec_t dec_in, dec_out;

   // Decode ahead of the buffer so held entries already carry the decoded record
   always_comb begin
      dec_in         = '0;
      dec_in.opcode  = ID_instruction[INSTR_W-1 -: OPC_W];
      dec_in.p1      = ID_instruction[2*PARAM_W-1 -: PARAM_W];
      dec_in.p2      = ID_instruction[PARAM_W-1:0];
      dec_in.is_imm  = IMM_MASK[dec_in.opcode];
      dec_in.illegal = ~LEGAL_MASK[dec_in.opcode];
      if (dec_in.is_imm) dec_in.imm = IMM_W'($signed(dec_in.p2));
   end

   id_skid_buf #(.W($bits(dec_t))) u_skid (
      .core_clk (ID_clock),
      .arst_n   (ID_reset),
      .flush    (ID_flush),
      .in_vld   (ID_in_valid),
      .in_rdy   (ID_in_ready),
      .in_dat   (dec_in),
      .out_vld  (ID_out_valid),
      .out_rdy  (ID_out_ready),
      .out_dat  (dec_out)
   );

   assign opcode     = dec_out.opcode;
   assign parameter1 = dec_out.p1;
   assign parameter2 = dec_out.p2;
   assign immediate  = dec_out.imm;
   assign is_imm     = dec_out.is_imm;
   assign illegal    = dec_out.illegal;

`ifdef ID_PERF_EN
   logic [15:0] stall_q;

   // Count cycles where a decoded beat waits on downstream; saturating, flush does not clear it
   always_ff @(posedge ID_clock or negedge ID_reset) begin
      if (!ID_reset) begin
         stall_q <= '0;
      end else if (ID_out_valid && !ID_out_ready && stall_q != 16'hFFFF) begin
         stall_q <= stall_q + 16'd1;
      end
   end

   assign stall_cycles = stall_q;
`else
   assign stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_id_decode_stage.sv
module tb_id_decode_stage;

   localparam logic [15:0] LEGAL_M = 16'h7FFF;
   localparam logic [15:0] IMM_M   = 16'h000C;

   logic        ID_clock = 1'b0;
   logic        ID_reset;
   logic        ID_flush;
   logic        ID_in_valid;
   logic        ID_in_ready;
   logic [15:0] ID_instruction;
   logic        ID_out_valid;
   logic        ID_out_ready;
   logic [3:0]  opcode;
   logic [5:0]  parameter1;
   logic [5:0]  parameter2;
   logic [15:0] immediate;
   logic        is_imm;
   logic        illegal;
   logic [15:0] stall_cycles;

   int n_checks = 0;
   int n_fail   = 0;

   id_decode_stage #(
      .INSTR_W(16), .OPC_W(4), .PARAM_W(6), .IMM_W(16),
      .LEGAL_MASK(LEGAL_M), .IMM_MASK(IMM_M)
   ) dut (
      .ID_clock(ID_clock), .ID_reset(ID_reset), .ID_flush(ID_flush),
      .ID_in_valid(ID_in_valid), .ID_in_ready(ID_in_ready), .ID_instruction(ID_instruction),
      .ID_out_valid(ID_out_valid), .ID_out_ready(ID_out_ready),
      .opcode(opcode), .parameter1(parameter1), .parameter2(parameter2),
      .immediate(immediate), .is_imm(is_imm), .illegal(illegal), .stall_cycles(stall_cycles)
   );

   always #5 ID_clock = ~ID_clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- model: plain queue of instructions in flight ----------------
   logic [15:0] q[$];
   logic [15:0] m_stall = 16'h0;

   function automatic logic [31:0] m_op(input logic [15:0] ins);
      return 32'(ins >> 12);
   endfunction
   function automatic logic [31:0] m_p1(input logic [15:0] ins);
      return 32'((ins >> 6) & 16'h3F);
   endfunction
   function automatic logic [31:0] m_p2(input logic [15:0] ins);
      return 32'(ins & 16'h3F);
   endfunction
   function automatic logic [31:0] m_isimm(input logic [15:0] ins);
      return 32'((IMM_M >> (ins >> 12)) & 16'h1);
   endfunction
   function automatic logic [31:0] m_illegal(input logic [15:0] ins);
      return (((LEGAL_M >> (ins >> 12)) & 16'h1) == 16'h0) ? 32'd1 : 32'd0;
   endfunction
   function automatic logic [31:0] m_imm(input logic [15:0] ins);
      logic [31:0] p;
      p = m_p2(ins);
      if (m_isimm(ins) == 32'd0) return 32'd0;
      if (p >= 32) return p + 32'h0000_FFC0;
      return p;
   endfunction

   always @(posedge ID_clock or negedge ID_reset) begin
      if (!ID_reset) begin
         q.delete();
         m_stall = 16'h0;
      end else begin
         bit acc, drn;
         acc = ID_in_valid && (q.size() < 2);
         drn = (q.size() > 0) && ID_out_ready;
`ifdef ID_PERF_EN
         if (q.size() > 0 && !ID_out_ready && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
`endif
         if (ID_flush) begin
            q.delete();
         end else begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(ID_instruction);
         end
      end
   end

   // Compare every cycle, away from the rising edge
   always @(negedge ID_clock) begin
      if (!ID_reset) begin
         check("rst_in_ready", 32'(ID_in_ready), 32'd1);
         check("rst_out_valid", 32'(ID_out_valid), 32'd0);
         check("rst_fields", {opcode, parameter1, parameter2, is_imm, illegal}, 32'd0);
         check("rst_imm", 32'(immediate), 32'd0);
         check("rst_stall", 32'(stall_cycles), 32'd0);
      end else begin
         check("in_ready", 32'(ID_in_ready), (q.size() < 2) ? 32'd1 : 32'd0);
         check("out_valid", 32'(ID_out_valid), (q.size() > 0) ? 32'd1 : 32'd0);
         check("stall_cycles", 32'(stall_cycles), 32'(m_stall));
         if (q.size() > 0) begin
            check("opcode", 32'(opcode), m_op(q[0]));
            check("parameter1", 32'(parameter1), m_p1(q[0]));
            check("parameter2", 32'(parameter2), m_p2(q[0]));
            check("is_imm", 32'(is_imm), m_isimm(q[0]));
            check("immediate", 32'(immediate), m_imm(q[0]));
            check("illegal", 32'(illegal), m_illegal(q[0]));
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic step(input logic v, input logic [15:0] ins, input logic ordy, input logic fl);
      ID_in_valid    = v;
      ID_instruction = ins;
      ID_out_ready   = ordy;
      ID_flush       = fl;
      @(posedge ID_clock);
      #1;
   endtask

   localparam logic [15:0] A = 16'h5041; // op5 p1=1 p2=1
   localparam logic [15:0] B = 16'h6082; // op6 p1=2 p2=2
   localparam logic [15:0] C = 16'h70C3; // op7 p1=3 p2=3

   logic [31:0] stall_exp;

   initial begin
`ifdef ID_PERF_EN
      stall_exp = 32'd10;
`else
      stall_exp = 32'd0;
`endif
      ID_reset = 1'b0; ID_flush = 1'b0; ID_in_valid = 1'b0;
      ID_instruction = 16'h0; ID_out_ready = 1'b0;
      #12;
      check("t0_in_ready", 32'(ID_in_ready), 32'd1);
      check("t0_out_valid", 32'(ID_out_valid), 32'd0);
      check("t0_opcode", 32'(opcode), 32'd0);
      ID_reset = 1'b1;
      @(posedge ID_clock); #1;

      // 1: register-format beat
      step(1'b1, 16'b0001_000001_000001, 1'b1, 1'b0);
      check("t1_out_valid", 32'(ID_out_valid), 32'd1);
      check("t1_opcode", 32'(opcode), 32'd1);
      check("t1_p1", 32'(parameter1), 32'd1);
      check("t1_p2", 32'(parameter2), 32'd1);
      check("t1_is_imm", 32'(is_imm), 32'd0);
      check("t1_imm", 32'(immediate), 32'd0);
      check("t1_illegal", 32'(illegal), 32'd0);

      // 2: immediate format, negative and positive parameter2
      step(1'b1, 16'b0010_001100_110011, 1'b1, 1'b0);
      check("t2_opcode", 32'(opcode), 32'd2);
      check("t2_p1", 32'(parameter1), 32'd12);
      check("t2_p2", 32'(parameter2), 32'd51);
      check("t2_is_imm", 32'(is_imm), 32'd1);
      check("t2_imm", 32'(immediate), 32'h0000_FFF3);
      step(1'b1, 16'b0011_000010_000101, 1'b1, 1'b0);
      check("t2b_imm", 32'(immediate), 32'd5);
      step(1'b0, 16'h0, 1'b1, 1'b0);
      check("t2_drained", 32'(ID_out_valid), 32'd0);

      // 3: backpressure with three back-to-back beats
      step(1'b1, A, 1'b0, 1'b0);
      check("t3_rdy_one", 32'(ID_in_ready), 32'd1);
      step(1'b1, B, 1'b0, 1'b0);
      check("t3_rdy_full", 32'(ID_in_ready), 32'd0);
      check("t3_hold_a", 32'(opcode), 32'd5);
      step(1'b1, C, 1'b0, 1'b0);
      check("t3_still_a", 32'(opcode), 32'd5);
      step(1'b1, C, 1'b1, 1'b0);
      check("t3_b_out", 32'(opcode), 32'd6);
      check("t3_b_p1", 32'(parameter1), 32'd2);
      check("t3_rdy_back", 32'(ID_in_ready), 32'd1);
      step(1'b1, C, 1'b1, 1'b0);
      check("t3_c_out", 32'(opcode), 32'd7);
      step(1'b0, 16'h0, 1'b1, 1'b0);
      check("t3_empty", 32'(ID_out_valid), 32'd0);

      // 4: illegal opcode still delivered
      step(1'b1, 16'hF000, 1'b1, 1'b0);
      check("t4_valid", 32'(ID_out_valid), 32'd1);
      check("t4_opcode", 32'(opcode), 32'd15);
      check("t4_illegal", 32'(illegal), 32'd1);
      step(1'b0, 16'h0, 1'b1, 1'b0);

      // 5: flush from FULL with a beat offered in the same cycle
      step(1'b1, A, 1'b0, 1'b0);
      step(1'b1, B, 1'b0, 1'b0);
      step(1'b1, C, 1'b0, 1'b1);
      check("t5_out_valid", 32'(ID_out_valid), 32'd0);
      check("t5_in_ready", 32'(ID_in_ready), 32'd1);
      step(1'b0, 16'h0, 1'b1, 1'b0);
      check("t5_gone", 32'(ID_out_valid), 32'd0);
      step(1'b0, 16'h0, 1'b1, 1'b0);
      check("t5_gone2", 32'(ID_out_valid), 32'd0);

      // 6: stall counter from a clean reset, then async reset mid-stream
      #1 ID_reset = 1'b0;
      #1 check("t6_rst_valid", 32'(ID_out_valid), 32'd0);
      @(negedge ID_clock); #1 ID_reset = 1'b1;
      @(posedge ID_clock); #1;
      step(1'b1, A, 1'b0, 1'b0);
      repeat (10) step(1'b0, 16'h0, 1'b0, 1'b0);
      check("t6_stall", 32'(stall_cycles), stall_exp);
      check("t6_valid", 32'(ID_out_valid), 32'd1);
      #1 ID_reset = 1'b0;
      #1;
      check("t6_async_valid", 32'(ID_out_valid), 32'd0);
      check("t6_async_ready", 32'(ID_in_ready), 32'd1);
      check("t6_async_opcode", 32'(opcode), 32'd0);
      check("t6_async_stall", 32'(stall_cycles), 32'd0);
      @(negedge ID_clock); #1 ID_reset = 1'b1;
      @(posedge ID_clock); #1;

      // Mixed traffic with toggling backpressure and one flush, checked by the model
      for (int i = 0; i < 48; i++) begin
         step((i % 3) != 0, 16'(i * 32'h1357 + 32'h00A5), (i % 4) != 1, i == 30);
      end
      repeat (4) step(1'b0, 16'h0, 1'b1, 1'b0);
      check("end_empty", 32'(ID_out_valid), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
